// File: rtl/apb_bridge_pkg.sv
// Shared types and address-map constants for the APB side of the AHB-to-APB bridge.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2
  } state_t;

  localparam int NUM_SLV = 4;

  // Address fields: upper tag selects the APB window, the next two bits pick the slave.
  localparam int TAG_HI = 31;
  localparam int TAG_LO = 26;
  localparam int SLV_HI = 25;
  localparam int SLV_LO = 24;

  localparam logic [TAG_HI-TAG_LO:0] DEC_TAG_DEFAULT = 6'b100000;

  function automatic logic [NUM_SLV-1:0] slv_onehot(input logic [SLV_HI-SLV_LO:0] idx);
    logic [NUM_SLV-1:0] sel;
    sel      = '0;
    sel[idx] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Request/response handshake plus APB bus signals of the bridge's APB master controller.
interface apb_master_ctrl_if
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic               req_valid;
  logic               req_ready;
  logic               req_write;
  logic [ADDR_W-1:0]  req_addr;
  logic [DATA_W-1:0]  req_wdata;

  logic               rsp_valid;
  logic               rsp_err;
  logic [DATA_W-1:0]  rsp_rdata;

  logic [NUM_SLV-1:0] Pselx;
  logic               Penable;
  logic               Pwrite;
  logic [ADDR_W-1:0]  Paddr;
  logic [DATA_W-1:0]  Pwdata;
  logic [DATA_W-1:0]  Prdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, Prdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
           Pselx, Penable, Pwrite, Paddr, Pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, Prdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
           Pselx, Penable, Pwrite, Paddr, Pwdata
  );

endinterface

// File: rtl/apb_addr_decode.sv
// Combinational address decoder: in-range flag from the tag field, one-hot slave select.
module apb_addr_decode
  import apb_bridge_pkg::*;
#(
  parameter logic [TAG_HI-TAG_LO:0] DEC_TAG = DEC_TAG_DEFAULT
) (
  input  logic [TAG_HI:SLV_LO] addr_top,
  output logic                 in_range,
  output logic [NUM_SLV-1:0]   sel
);

  // Select is forced to zero out of range so it can never leak onto Pselx.
  always_comb begin
    in_range = (addr_top[TAG_HI:TAG_LO] == DEC_TAG);
    sel      = in_range ? slv_onehot(addr_top[SLV_HI:SLV_LO]) : '0;
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB transfer controller of the AHB-to-APB bridge (IDLE/SETUP/ENABLE, registered outputs).
// Optional back-to-back transfers (accept in ENABLE) are enabled by APB_BACK_TO_BACK_EN.
module apb_master_ctrl
  import apb_bridge_pkg::*;
#(
  parameter int                     ADDR_W  = 32,
  parameter int                     DATA_W  = 32,
  parameter logic [TAG_HI-TAG_LO:0] DEC_TAG = DEC_TAG_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  apb_master_ctrl_if.master bus
);

  state_t             state;
  logic               in_range;
  logic [NUM_SLV-1:0] dec_sel;
  logic               accept;
  logic               launch;

`ifdef APB_BACK_TO_BACK_EN
  logic err_pend;
  localparam logic READY_IN_ENABLE = 1'b1;
`else
  localparam logic READY_IN_ENABLE = 1'b0;
`endif

  apb_addr_decode #(
    .DEC_TAG (DEC_TAG)
  ) u_decode (
    .addr_top (bus.req_addr[TAG_HI:SLV_LO]),
    .in_range (in_range),
    .sel      (dec_sel)
  );

  always_comb begin
    accept = bus.req_valid && bus.req_ready;
    launch = accept && in_range;
  end

  // Single FSM register block; launch relatches the APB address phase on every SETUP entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= {DATA_W{1'b0}};
      bus.Pselx     <= '0;
      bus.Penable   <= 1'b0;
      bus.Pwrite    <= 1'b0;
      bus.Paddr     <= {ADDR_W{1'b0}};
      bus.Pwdata    <= {DATA_W{1'b0}};
`ifdef APB_BACK_TO_BACK_EN
      err_pend      <= 1'b0;
`endif
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= {DATA_W{1'b0}};

      case (state)
        IDLE: begin
`ifdef APB_BACK_TO_BACK_EN
          if (err_pend) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.req_ready <= 1'b0;
            err_pend      <= 1'b0;
          end else
`endif
          if (launch) begin
            state         <= SETUP;
            bus.req_ready <= 1'b0;
          end else if (accept) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.req_ready <= 1'b0;
          end else begin
            bus.req_ready <= 1'b1;
          end
        end

        SETUP: begin
          bus.Penable   <= 1'b1;
          bus.req_ready <= READY_IN_ENABLE;
          state         <= ENABLE;
        end

        ENABLE: begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_rdata <= bus.Pwrite ? {DATA_W{1'b0}} : bus.Prdata;
          bus.Penable   <= 1'b0;
          bus.Pselx     <= '0;
`ifdef APB_BACK_TO_BACK_EN
          // An error accepted here answers one cycle after the current response.
          if (launch) begin
            state         <= SETUP;
            bus.req_ready <= 1'b0;
          end else if (accept) begin
            state         <= IDLE;
            err_pend      <= 1'b1;
            bus.req_ready <= 1'b0;
          end else begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
          end
`else
          state         <= IDLE;
          bus.req_ready <= 1'b1;
`endif
        end

        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b0;
          bus.Penable   <= 1'b0;
          bus.Pselx     <= '0;
        end
      endcase

      if (launch) begin
        bus.Paddr  <= bus.req_addr;
        bus.Pwrite <= bus.req_write;
        bus.Pselx  <= dec_sel;
        if (bus.req_write) begin
          bus.Pwdata <= bus.req_wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: directed cases then random traffic against a
// transaction-level timeline model (honours APB_BACK_TO_BACK_EN when defined).
module tb_apb_master_ctrl;

  localparam int N = 16384;
`ifdef APB_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  apb_master_ctrl_if bus ();

  apb_master_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc;
  int ready_from;
  int enable_cyc;
  bit accepted;

  // Expected timeline, indexed by cycle number.
  bit          e_rst    [N];
  bit          e_launch [N];
  bit          e_pen    [N];
  bit          e_valid  [N];
  bit          e_err    [N];
  logic [3:0]  e_sel    [N];
  int          e_rd     [N];
  logic [31:0] l_addr   [N];
  logic [31:0] l_wdata  [N];
  bit          l_write  [N];
  logic [31:0] prdata_hist [N];

  logic [31:0] h_addr, h_wdata;
  logic        h_write;
  logic        prev_pen;
  logic [31:0] prev_addr;
  bit          addr_chg;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic checkCycle();
    logic [31:0] exp_rd;
    if (e_rst[cyc]) begin
      h_addr  = '0;
      h_write = 1'b0;
      h_wdata = '0;
    end
    if (e_launch[cyc]) begin
      h_addr  = l_addr[cyc];
      h_write = l_write[cyc];
      if (l_write[cyc]) h_wdata = l_wdata[cyc];
    end
    exp_rd = (e_rd[cyc] >= 0) ? prdata_hist[e_rd[cyc]] : 32'h0;

    checkOutput("req_ready", bus.req_ready, (cyc >= ready_from));
    checkOutput("Pselx",     bus.Pselx,     e_sel[cyc]);
    checkOutput("Penable",   bus.Penable,   e_pen[cyc]);
    checkOutput("Paddr",     bus.Paddr,     h_addr);
    checkOutput("Pwrite",    bus.Pwrite,    h_write);
    checkOutput("Pwdata",    bus.Pwdata,    h_wdata);
    checkOutput("rsp_valid", bus.rsp_valid, e_valid[cyc]);
    checkOutput("rsp_err",   bus.rsp_err,   e_err[cyc]);
    checkOutput("rsp_rdata", bus.rsp_rdata, exp_rd);

    checkOutput("psel_onehot0", $onehot0(bus.Pselx), 1);
    if (prev_pen) checkOutput("penable_single", bus.Penable, 0);
    if (addr_chg && !e_rst[cyc]) checkOutput("paddr_then_penable", bus.Penable, 1);
    addr_chg  = (bus.Paddr !== prev_addr) && !e_rst[cyc];
    prev_pen  = bus.Penable;
    prev_addr = bus.Paddr;
  endtask

  // Drive one cycle of inputs, update the model for that cycle's handshake, then check the next.
  task automatic applyStimulus(input logic v, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] prd, input logic rst);
    int r;
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.Prdata    = prd;
    reset         = rst;
    prdata_hist[cyc] = prd;
    accepted = 1'b0;

    if (rst) begin
      for (int k = 1; k <= 4; k++) begin
        e_launch[cyc+k] = 1'b0;
        e_pen[cyc+k]    = 1'b0;
        e_valid[cyc+k]  = 1'b0;
        e_err[cyc+k]    = 1'b0;
        e_sel[cyc+k]    = 4'b0;
        e_rd[cyc+k]     = -1;
      end
      e_rst[cyc+1] = 1'b1;
      ready_from   = cyc + 2;
      enable_cyc   = -10;
    end else if (v && cyc >= ready_from) begin
      accepted = 1'b1;
      if (a[31:26] == 6'b100000) begin
        e_launch[cyc+1] = 1'b1;
        l_addr[cyc+1]   = a;
        l_write[cyc+1]  = w;
        l_wdata[cyc+1]  = d;
        e_sel[cyc+1]    = 4'b0001 << a[25:24];
        e_sel[cyc+2]    = 4'b0001 << a[25:24];
        e_pen[cyc+2]    = 1'b1;
        e_valid[cyc+3]  = 1'b1;
        e_err[cyc+3]    = 1'b0;
        e_rd[cyc+3]     = w ? -1 : cyc + 2;
        enable_cyc      = cyc + 2;
        ready_from      = cyc + (B2B ? 2 : 3);
      end else begin
        r = (B2B && cyc == enable_cyc) ? cyc + 2 : cyc + 1;
        e_valid[r] = 1'b1;
        e_err[r]   = 1'b1;
        e_rd[r]    = -1;
        ready_from = r + 1;
      end
    end

    @(posedge clock);
    @(negedge clock);
    cyc++;
    checkCycle();
  endtask

  task automatic idle(input int n, input logic [31:0] prd);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, prd, 1'b0);
  endtask

  task automatic sendReq(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] prd);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      applyStimulus(1'b1, w, a, d, prd, 1'b0);
      got = accepted;
    end
    checkOutput("req_accept", got, 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int xfers;
    logic [31:0] rnd, addr;
    logic v, w, rst;

    for (int k = 0; k < N; k++) begin
      e_rst[k] = 1'b0; e_launch[k] = 1'b0; e_pen[k] = 1'b0;
      e_valid[k] = 1'b0; e_err[k] = 1'b0; e_sel[k] = 4'b0; e_rd[k] = -1;
      l_addr[k] = '0; l_wdata[k] = '0; l_write[k] = 1'b0; prdata_hist[k] = '0;
    end
    e_rst[0]   = 1'b1;
    ready_from = 1 << 30;
    enable_cyc = -10;
    prev_pen   = 1'b0;
    prev_addr  = '0;
    addr_chg   = 1'b0;

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.Prdata    = '0;

    @(posedge clock);
    @(negedge clock);
    cyc = 0;
    checkCycle();

    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    idle(2, 32'h0);

    $display("[TB] single write and read");
    sendReq(1'b1, 32'h8100_0010, 32'hDEAD_BEEF, 32'h0);
    idle(4, 32'h0BAD_F00D);
    sendReq(1'b0, 32'h8300_0004, 32'h0, 32'h1234_5678);
    idle(4, 32'h1234_5678);

    $display("[TB] out-of-range read");
    sendReq(1'b0, 32'h4000_0000, 32'h0, 32'h0);
    idle(3, 32'h0);

    $display("[TB] back-to-back writes");
    sendReq(1'b1, 32'h8000_0000, 32'h1111_1111, 32'h0);
    sendReq(1'b1, 32'h8200_0000, 32'h2222_2222, 32'h0);
    idle(5, 32'h0);

    $display("[TB] reset during ENABLE");
    sendReq(1'b0, 32'h8000_0008, 32'h0, 32'hCAFE_0001);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE_0001, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE_0001, 1'b1);
    idle(2, 32'h0);
    sendReq(1'b0, 32'h8000_0008, 32'h0, 32'hCAFE_0002);
    idle(4, 32'hCAFE_0002);

    $display("[TB] request coincident with reset");
    applyStimulus(1'b1, 1'b1, 32'h8100_0000, 32'h0000_0005, 32'h0, 1'b1);
    idle(3, 32'h0);

    $display("[TB] transfer followed by out-of-range request");
    sendReq(1'b1, 32'h8000_0100, 32'h0000_0033, 32'h0);
    sendReq(1'b0, 32'h0000_0000, 32'h0, 32'h0);
    idle(4, 32'h0);

    $display("[TB] random traffic");
    xfers = 0;
    for (int i = 0; i < 12000 && xfers < 1000; i++) begin
      rnd = $urandom();
      v   = ($urandom_range(0, 9) < 7);
      w   = rnd[31];
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) < 8) begin
        addr = {6'b100000, rnd[25:0]};
      end else begin
        addr = $urandom();
        if (addr[31:26] == 6'b100000) addr[31] = 1'b0;
      end
      applyStimulus(v, w, addr, $urandom(), $urandom(), rst);
      if (accepted) xfers++;
    end
    checkOutput("random_transfer_count", (xfers >= 1000), 1);
    idle(6, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
